// File: rtl/delay_ctrl_pkg.sv
// Shared types for the delay reconfiguration controller: FSM state encoding,
// the default delay word and the counter-width helper.
package delay_ctrl_pkg;

    localparam int DELAY_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_FLUSH     = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_FILL      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    typedef logic [DELAY_W_DEF-1:0] delay_t;

    // Bits needed to hold the largest of three terminal counts (at least 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear, count enable and a
// terminal-count flag against a caller-supplied terminal value.
module cycle_counter #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins over enable, and the value sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == i_term);

endmodule

// File: rtl/delay_reconfig_ctrl.sv
// Delay reconfiguration controller: FLUSH -> WAIT_BUSY -> FILL -> RUN.
// Define DELAY_CLAMP_EN to clamp out-of-range requests to MAX_DELAY instead of rejecting them.
module delay_reconfig_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int MAX_DELAY_CNT_WIDTH = DELAY_W_DEF,
    parameter int MAX_DELAY           = 31,
    parameter int INIT_DELAY          = 4,
    parameter int RST_CYCLES          = 10,
    parameter int BUSY_TIMEOUT        = 64
) (
    input  logic                           CLK,
    input  logic                           RESETN,
    input  logic [MAX_DELAY_CNT_WIDTH-1:0] REQ_DELAY,
    input  logic                           REQ_VALID,
    output logic                           REQ_READY,
    input  logic                           FIFO_RST_BUSY,
    output logic [MAX_DELAY_CNT_WIDTH-1:0] DELAY,
    output logic                           LOCAL_RESETN,
    output logic                           DELAY_VALID,
    output logic                           ERR,
    output logic                           CLAMPED
);

    localparam int CNT_W = cnt_width(RST_CYCLES - 1, BUSY_TIMEOUT - 1, MAX_DELAY);

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [MAX_DELAY_CNT_WIDTH-1:0]   r_delay;
    logic [MAX_DELAY_CNT_WIDTH-1:0]   w_delay_nxt;
    logic                             r_local_resetn;
    logic                             r_delay_valid;
    logic                             r_req_ready;
    logic                             r_err;
    logic                             r_clamped;
    logic                             w_err_set;
    logic                             w_clamp;
    logic                             w_oor;
    logic                             w_cnt_clr;
    logic                             w_cnt_en;
    logic [CNT_W-1:0]                 w_term;
    logic                             w_tc;

    assign w_oor = (REQ_DELAY > MAX_DELAY_CNT_WIDTH'(MAX_DELAY));

    cycle_counter #(.WIDTH(CNT_W)) u_cycle_counter (
        .i_clk   (CLK),
        .i_rst_n (RESETN),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_term  (w_term),
        .o_tc    (w_tc)
    );

    // Next-state logic; every state transition clears the shared counter.
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_err_set   = 1'b0;
        w_clamp     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_term      = {CNT_W{1'b0}};
        case (r_state)
            ST_FLUSH: begin
                w_term = CNT_W'(RST_CYCLES - 1);
                if (w_tc) begin
                    w_state_nxt = ST_WAIT_BUSY;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_WAIT_BUSY: begin
                w_term = CNT_W'(BUSY_TIMEOUT - 1);
                if (!FIFO_RST_BUSY) begin
                    w_state_nxt = ST_FILL;
                    w_cnt_clr   = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt = ST_FLUSH;
                    w_err_set   = 1'b1;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_FILL: begin
                w_term = CNT_W'(r_delay);
                if (w_tc) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_RUN: begin
                if (REQ_VALID) begin
                    if (w_oor) begin
`ifdef DELAY_CLAMP_EN
                        w_delay_nxt = MAX_DELAY_CNT_WIDTH'(MAX_DELAY);
                        w_clamp     = 1'b1;
                        w_state_nxt = ST_FLUSH;
                        w_cnt_clr   = 1'b1;
`else
                        w_err_set   = 1'b1;
`endif
                    end else begin
                        w_delay_nxt = REQ_DELAY;
                        w_state_nxt = ST_FLUSH;
                        w_cnt_clr   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_FLUSH;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    // State and outputs registered together so outputs track the state they describe.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state        <= ST_FLUSH;
            r_delay        <= MAX_DELAY_CNT_WIDTH'(INIT_DELAY);
            r_local_resetn <= 1'b0;
            r_delay_valid  <= 1'b0;
            r_req_ready    <= 1'b0;
            r_err          <= 1'b0;
            r_clamped      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_delay        <= w_delay_nxt;
            r_local_resetn <= (w_state_nxt != ST_FLUSH);
            r_delay_valid  <= (w_state_nxt == ST_RUN);
            r_req_ready    <= (w_state_nxt == ST_RUN);
            r_err          <= r_err | w_err_set;
            r_clamped      <= w_clamp;
        end
    end

    assign DELAY        = r_delay;
    assign LOCAL_RESETN = r_local_resetn;
    assign DELAY_VALID  = r_delay_valid;
    assign REQ_READY    = r_req_ready;
    assign ERR          = r_err;
    assign CLAMPED      = r_clamped;

endmodule

// File: doc/delay_reconfig_ctrl.md
DELAY_RECONFIG_CTRL -- requirements
Module: delay_reconfig_ctrl

Interface
REQ-001 Parameter MAX_DELAY_CNT_WIDTH, default 7: width of the delay value.
REQ-002 Parameter MAX_DELAY, default 31: largest legal delay, which is FIFO DEPTH-1.
REQ-003 Parameter INIT_DELAY, default 4: delay applied after global reset.
REQ-004 Parameter RST_CYCLES, default 10: number of cycles LOCAL_RESETN is held low.
REQ-005 Parameter BUSY_TIMEOUT, default 64: maximum cycles to wait in WAIT_BUSY.
REQ-006 Port CLK, input, 1 bit: single clock; all logic rises on its posedge.
REQ-007 Port RESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port REQ_DELAY, input, MAX_DELAY_CNT_WIDTH bits: requested new delay.
REQ-009 Port REQ_VALID, input, 1 bit: a delay-change request is present.
REQ-010 Port REQ_READY, output, 1 bit: the controller accepts a request this cycle.
REQ-011 Port FIFO_RST_BUSY, input, 1 bit: the delay FIFO is still in reset.
REQ-012 Port DELAY, output, MAX_DELAY_CNT_WIDTH bits: registered delay driven to the delay module.
REQ-013 Port LOCAL_RESETN, output, 1 bit: active-low reset to the delay module and its FIFO.
REQ-014 Port DELAY_VALID, output, 1 bit: the delayed output stream is valid.
REQ-015 Port ERR, output, 1 bit: sticky error flag.
REQ-016 Port CLAMPED, output, 1 bit: one-cycle pulse when a request was clamped (macro builds only).

Function
REQ-017 The controller SHALL implement the states FLUSH, WAIT_BUSY, FILL and RUN.
REQ-018 A request SHALL be accepted when REQ_VALID and REQ_READY are both 1 on a rising edge.
REQ-019 REQ_READY SHALL be 1 only in RUN.
REQ-020 On acceptance, DELAY SHALL load REQ_DELAY at that edge and the state SHALL become FLUSH.
REQ-021 FLUSH behaviour:
- LOCAL_RESETN=0 for exactly RST_CYCLES cycles.
- Then go to WAIT_BUSY.
REQ-022 WAIT_BUSY behaviour:
- LOCAL_RESETN=1.
- Go to FILL on the first edge where FIFO_RST_BUSY=0.
REQ-023 If WAIT_BUSY lasts BUSY_TIMEOUT cycles, the controller SHALL set ERR and re-enter FLUSH (retry).
REQ-024 FILL behaviour:
- Count DELAY+1 cycles with DELAY_VALID=0.
- Then go to RUN.
- When DELAY=0, FILL lasts exactly 1 cycle.
REQ-025 In RUN, DELAY_VALID SHALL be 1 and DELAY SHALL be held.
REQ-026 A request arriving while not in RUN SHALL be stalled by REQ_READY=0; it SHALL NOT be dropped or queued internally.
REQ-027 FIFO_RST_BUSY SHALL be ignored outside WAIT_BUSY.
REQ-028 If FIFO_RST_BUSY is 1 on the same edge a request is accepted, the request SHALL take priority (go to FLUSH).
REQ-029 A request with REQ_DELAY>MAX_DELAY SHALL be handled per REQ-034 and REQ-035.
REQ-030 All counters SHALL be sized with $clog2 of their maximum value and SHALL saturate rather than wrap.
REQ-031 ERR SHALL clear only on RESETN.

Reset
REQ-032 While RESETN=0, the outputs SHALL be:
- state=FLUSH, counter=0
- DELAY=INIT_DELAY
- LOCAL_RESETN=0, DELAY_VALID=0, REQ_READY=0
- ERR=0, CLAMPED=0
REQ-033 When RESETN is asserted mid-sequence, the sequence SHALL abort immediately; after release the full sequence SHALL restart with INIT_DELAY.

Configuration
REQ-034 With DELAY_CLAMP_EN defined, an out-of-range request SHALL be accepted with DELAY=MAX_DELAY and CLAMPED pulsed for 1 cycle.
REQ-035 Without DELAY_CLAMP_EN, an out-of-range request SHALL be consumed for 1 cycle but not applied: ERR=1, the state stays RUN, DELAY is unchanged, and CLAMPED is tied to 0.

Structure
REQ-036 A shared package delay_ctrl_pkg SHALL hold:
- the state enum (FLUSH, WAIT_BUSY, FILL, RUN)
- the delay typedef of width MAX_DELAY_CNT_WIDTH
REQ-037 One sub-module, cycle_counter, SHALL be used with load, enable, terminal-count output and saturation; it serves FLUSH, WAIT_BUSY and FILL.

Verification
REQ-038 Power-up scenario:
- Stimulus: release RESETN, FIFO_RST_BUSY falls 3 cycles after LOCAL_RESETN rises.
- Required: LOCAL_RESETN low for 10 cycles, DELAY=4, DELAY_VALID rises 5 cycles after leaving WAIT_BUSY.
REQ-039 Normal change scenario:
- Stimulus: in RUN, request REQ_DELAY=10.
- Required: DELAY=10 on the next edge, 10-cycle flush, then DELAY_VALID after 11 FILL cycles.
REQ-040 Stall scenario:
- Stimulus: request 7 held during FILL.
- Required: REQ_READY=0 until RUN; the request is accepted on the first RUN cycle and the flush restarts.
REQ-041 Timeout scenario:
- Stimulus: FIFO_RST_BUSY stuck at 1 for 64 cycles.
- Required: ERR=1 and a second FLUSH of 10 cycles.
REQ-042 Out-of-range scenario:
- Stimulus: request 100.
- Required with the macro: DELAY=31 and a CLAMPED pulse.
- Required without the macro: DELAY unchanged, ERR=1, DELAY_VALID stays 1.
REQ-043 Reset and zero-delay scenarios:
- Stimulus: assert RESETN in FILL, then request 0.
- Required: immediate reset values on RESETN; FILL lasts 1 cycle for delay 0.
